// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side stream adapter: output buffer occupancy
// encoding and the default data width.
package fifo_rd_pkg;
  localparam int DEF_DATA_WIDTH = 16;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry output buffer: ring storage with 1-bit pointers and an occupancy FSM.
// Registered output only; the head word is a mux of mem by rd_idx.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);
  occ_state_e state_q, state_d;
  logic [1:0][DATA_WIDTH-1:0] mem;
  logic wr_idx, rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case ({push, pop})
      2'b10: begin
        unique case (state_q)
          EMPTY:   state_d = ONE;
          ONE:     state_d = TWO;
          default: state_d = TWO;
        endcase
      end
      2'b01: begin
        unique case (state_q)
          TWO:     state_d = ONE;
          ONE:     state_d = EMPTY;
          default: state_d = EMPTY;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // mem is cleared so the head word reads zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && state_q == TWO));
      assert (!(pop && state_q == EMPTY));
    end
  end

  assign occ   = occ_t'(state_q);
  assign valid = (state_q != EMPTY);
  assign data  = mem[rd_idx];
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns a registered-read FIFO port into a valid/ready stream at one word per clock.
// Optional FIFO_RD_STATS_EN adds saturating words_out / stall_cycles counters.
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           words_out,
  output logic [31:0]           stall_cycles
`endif
);
  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("fifo_rd_stream_adapter: BUF_DEPTH must be 2");
  end

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] occ_after;

  assign pop = m_valid && m_ready;
  // pop implies occ >= 1, so this never goes negative
  assign occ_after  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (occ_after < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  fifo_rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .data      (m_data),
    .valid     (m_valid)
  );

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_out    <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop && words_out != 32'hFFFF_FFFF) words_out <= words_out + 32'd1;
      if (m_valid && !m_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a registered-read FIFO model.
module tb_fifo_rd_stream_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_out, stall_cycles;
`endif

  int n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  logic [15:0] recv[$];
  int rd_cnt = 0, underflow = 0;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.DATA_WIDTH(16), .BUF_DEPTH(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_out    (words_out),
    .stall_cycles (stall_cycles)
`endif
  );

  // FIFO model: data_out registered one cycle after rd_en; empty flag registered
  always @(posedge clk) begin
    if (!rst && fifo_rd_en) begin
      rd_cnt++;
      if (q.size() == 0) underflow++;
      else fifo_dout <= q.pop_front();
    end
    if (!rst && m_valid && m_ready) recv.push_back(m_data);
    fifo_empty <= (q.size() == 0);
  end

  function automatic logic [15:0] got(input int idx);
    logic [15:0] v;
    v = 16'hxxxx;
    if (idx < recv.size()) v = recv[idx];
    return v;
  endfunction

  task automatic start(input int n, input logic [15:0] base);
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b0; q.delete();
    for (int i = 0; i < n; i++) q.push_back(base + 16'(i));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    #1 rst = 1'b1;
    q.push_back(16'h1111);
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_chk++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", m_data); end
    @(negedge clk); rst = 1'b0; #1;
    n_chk++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL release_rd_en: got %b want 1", fifo_rd_en); end
    m_ready = 1'b1; base = recv.size();
    repeat (5) @(negedge clk);
    n_chk++; if (recv.size() != base + 1 || got(base) !== 16'h1111) begin
      n_fail++; $display("FAIL reset_first_word: got %h (n=%0d) want 1111", got(base), recv.size() - base); end
  endtask

  task automatic test_streaming();
    int first_rd, first_v, last_v, nv, base;
    first_rd = -1; first_v = -1; last_v = -1; nv = 0;
    start(8, 16'h0001);
    m_ready = 1'b1; base = recv.size();
    for (int c = 0; c < 25; c++) begin
      #1;
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c; nv++;
      end
      @(negedge clk);
    end
    n_chk++; if (first_v - first_rd !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", first_v - first_rd); end
    n_chk++; if (nv !== 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", nv); end
    n_chk++; if (last_v - first_v !== 7) begin n_fail++; $display("FAIL stream_contig: got %0d want 7", last_v - first_v); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (got(base + i) !== 16'(i + 1)) begin
        n_fail++; $display("FAIL stream_word%0d: got %h want %h", i, got(base + i), 16'(i + 1)); end
    end
    n_chk++; if (underflow !== 0) begin n_fail++; $display("FAIL stream_underflow: got %0d want 0", underflow); end
  endtask

  task automatic test_backpressure();
    int rd0, base;
    logic [15:0] held;
    start(5, 16'h0A00);
    rd0 = rd_cnt;
    repeat (4) @(negedge clk);
    #1 held = m_data;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (rd_cnt - rd0 !== 2) begin n_fail++; $display("FAIL bp_reads: got %0d want 2", rd_cnt - rd0); end
    n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    n_chk++; if (m_data !== 16'h0A00 || held !== 16'h0A00) begin
      n_fail++; $display("FAIL bp_hold: got %h/%h want 0a00", held, m_data); end
    n_chk++; if (q.size() !== 3) begin n_fail++; $display("FAIL bp_fifo_left: got %0d want 3", q.size()); end
    @(negedge clk);
    base = recv.size(); m_ready = 1'b1;
    repeat (12) @(negedge clk);
    n_chk++; if (recv.size() - base !== 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", recv.size() - base); end
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (got(base + i) !== 16'h0A00 + 16'(i)) begin
        n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got(base + i), 16'h0A00 + 16'(i)); end
    end
  endtask

  task automatic test_drain();
    int rd0, base;
    start(1, 16'hABCD);
    m_ready = 1'b1; rd0 = rd_cnt; base = recv.size();
    repeat (6) @(negedge clk);
    #1;
    n_chk++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL drain_reads: got %0d want 1", rd_cnt - rd0); end
    n_chk++; if (recv.size() - base !== 1 || got(base) !== 16'hABCD) begin
      n_fail++; $display("FAIL drain_word: got %h (n=%0d) want abcd", got(base), recv.size() - base); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", m_valid); end
    n_chk++; if (underflow !== 0) begin n_fail++; $display("FAIL drain_underflow: got %0d want 0", underflow); end
  endtask

  task automatic test_mid_reset();
    int base;
    start(5, 16'h3000);
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
    n_chk++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0000", m_data); end
    n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en); end
    q.delete();
    repeat (2) @(negedge clk);
    q.push_back(16'h5A5A);
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b1; base = recv.size();
    repeat (6) @(negedge clk);
    n_chk++; if (recv.size() - base !== 1 || got(base) !== 16'h5A5A) begin
      n_fail++; $display("FAIL midrst_stale: got %h (n=%0d) want 5a5a", got(base), recv.size() - base); end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    int stalls, pops;
    stalls = 0; pops = 0;
    start(10, 16'h0100);
    for (int c = 0; c < 40 && pops < 10; c++) begin
      m_ready = (stalls >= 3);
      #1;
      if (m_valid && !m_ready) stalls++;
      if (m_valid && m_ready) pops++;
      @(negedge clk);
    end
    m_ready = 1'b0; #1;
    n_chk++; if (words_out !== 32'd10) begin n_fail++; $display("FAIL stats_words: got %0d want 10", words_out); end
    n_chk++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL stats_stalls: got %0d want 3", stall_cycles); end
    @(negedge clk);
    u_dut.words_out = 32'hFFFF_FFFE;
    u_dut.stall_cycles = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) q.push_back(16'h0200 + 16'(i));
    repeat (7) @(negedge clk);
    m_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++; if (words_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_words_sat: got %h want ffffffff", words_out); end
    n_chk++; if (stall_cycles !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_stalls_sat: got %h want ffffffff", stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_mid_reset();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
